// File: rtl/tt_adder_pkg.sv
// Shared definitions for the 8-bit adder tile.
//   WIDTH     : operand/sum width, fixed by the Tiny Tapeout pinout
//   operand_t : one operand or sum word
package tt_adder_pkg;
  localparam int WIDTH = 8;
  typedef logic [WIDTH-1:0] operand_t;
endpackage

// File: rtl/adder8_rca.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Purely combinational.
//   a, b : operands
//   cin  : carry into bit 0
//   sum  : a + b + cin, truncated to WIDTH bits
//   cout : carry out of the top bit
module adder8_rca
  import tt_adder_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  input  logic     cin,
  output operand_t sum,
  output logic     cout
);

  // w_c[i] is the carry into bit i; w_c[WIDTH] leaves the top cell.
  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[WIDTH];

endmodule

// File: rtl/tt_um_adder8.sv
// Tiny Tapeout tile: registered 8-bit unsigned adder.
//   clk     : system clock, rising edge
//   rst_n   : synchronous reset, active HIGH despite the harness name
//   ena     : 1 = load new sum, 0 = hold
//   ui_in   : operand A
//   uio_in  : operand B (all uio pins are inputs)
//   uo_out  : registered (A+B) mod 256, one cycle latency
//   uio_out : tied 0
//   uio_oe  : tied 0, the tile never drives uio
module tt_um_adder8
  import tt_adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe
);

  operand_t w_sum;
  logic     w_cout;

  operand_t r_sum_q;
  logic     r_carry_q;

  adder8_rca u_rca (
    .a    (ui_in),
    .b    (uio_in),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // rst_n is active high here: the harness name is kept, the polarity is not.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_sum_q   <= '0;
      r_carry_q <= 1'b0;
    end else if (ena) begin
      r_sum_q   <= w_sum;
      r_carry_q <= w_cout;
    end
  end

  // Carry is kept for simulation visibility only; it has no pin.
  logic w_unused_carry;
  assign w_unused_carry = r_carry_q;

  assign uo_out  = r_sum_q;
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_adder8.sv
module tb_tt_um_adder8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_adder8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: what the tile should be holding, from plain arithmetic.
  int m_sum   = 0;
  int m_carry = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model one rising edge with the inputs currently driven.
  task automatic model_edge();
    int s;
    s = int'(ui_in) + int'(uio_in);
    if (rst_n) begin
      m_sum = 0; m_carry = 0;
    end else if (ena) begin
      m_sum   = s % 256;
      m_carry = (s > 255) ? 1 : 0;
    end
  endtask

  // Advance one clock, update the model, settle to 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] a, input logic [7:0] b);
    rst_n = r; ena = e; ui_in = a; uio_in = b;
  endtask

  initial begin
    vecs[0] = '{8'd0,   8'd0,   8'd0,   1'b0};
    vecs[1] = '{8'd10,  8'd15,  8'd25,  1'b0};
    vecs[2] = '{8'd20,  8'd30,  8'd50,  1'b0};
    vecs[3] = '{8'd255, 8'd1,   8'd0,   1'b1};
    vecs[4] = '{8'd128, 8'd128, 8'd0,   1'b1};
    vecs[5] = '{8'd200, 8'd100, 8'd44,  1'b1};
    vecs[6] = '{8'd255, 8'd255, 8'd254, 1'b1};

    // Reset for two cycles, with ena high to show reset wins.
    drive(1'b1, 1'b1, 8'hAA, 8'h55);
    step();
    step();
    chk("reset_uo_out",  32'(uo_out),        32'h00);
    chk("reset_carry",   32'(dut.r_carry_q), 32'h0);
    chk("reset_uio_oe",  32'(uio_oe),        32'h00);
    chk("reset_uio_out", 32'(uio_out),       32'h00);

    // Table-driven adds.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, vecs[i].a, vecs[i].b);
      step();
      chk($sformatf("vec%0d_sum", i),   32'(uo_out),        32'(vecs[i].sum));
      chk($sformatf("vec%0d_carry", i), 32'(dut.r_carry_q), 32'(vecs[i].carry));
    end

    // Hold: 25 must survive three cycles of ena=0 with other operands.
    drive(1'b0, 1'b1, 8'd10, 8'd15);
    step();
    chk("hold_load", 32'(uo_out), 32'd25);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'd1, 8'd1);
      step();
      chk($sformatf("hold_cyc%0d", i), 32'(uo_out), 32'd25);
    end
    chk("uio_oe_run",  32'(uio_oe),  32'h00);
    chk("uio_out_run", 32'(uio_out), 32'h00);

    // Reset mid-stream, then idle, then first post-reset sum.
    drive(1'b1, 1'b1, 8'd9, 8'd9);
    step();
    chk("midrst_uo", 32'(uo_out), 32'd0);
    drive(1'b0, 1'b0, 8'd3, 8'd4);
    step();
    chk("midrst_idle", 32'(uo_out), 32'd0);
    drive(1'b0, 1'b1, 8'd3, 8'd4);
    #1;
    chk("midrst_nocomb", 32'(uo_out), 32'd0);
    step();
    chk("midrst_first", 32'(uo_out), 32'd7);

    // Exhaustive back-to-back: one pair per cycle, each result one edge later.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive(1'b0, 1'b1, 8'(a), 8'(b));
        step();
        chk("exh_sum", 32'(uo_out), 32'((a + b) & 255));
      end
    end

    // Random traffic against the model, including no-same-cycle-change checks.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] prev;
      prev = uo_out;
      drive(($urandom_range(15) == 0), ($urandom_range(3) != 0),
            8'($urandom_range(255)), 8'($urandom_range(255)));
      #1;
      chk("rnd_nocomb", 32'(uo_out), 32'(prev));
      step();
      chk("rnd_sum",   32'(uo_out),        32'(m_sum));
      chk("rnd_carry", 32'(dut.r_carry_q), 32'(m_carry));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
